// File: rtl/load_bin.sv
// Streams one bin (clauses, variable states, level states) from the bin BRAMs into
// the SAT engine's per-slot arrays using one-hot write strobes.
module load_bin #(
    parameter int NUM_CLAUSES_A_BIN      = 8,
    parameter int NUM_VARS_A_BIN         = 8,
    parameter int NUM_LVLS_A_BIN         = 8,
    parameter int WIDTH_CLAUSES          = NUM_VARS_A_BIN * 2,
    parameter int WIDTH_VARS             = 12,
    parameter int WIDTH_LVL              = 16,
    parameter int WIDTH_BIN_ID           = 10,
    parameter int WIDTH_VAR_STATES       = 30,
    parameter int WIDTH_LVL_STATES       = 30,
    parameter int ADDR_WIDTH_CLAUSES     = 9,
    parameter int ADDR_WIDTH_VARS        = 9,
    parameter int ADDR_WIDTH_VARS_STATES = 9,
    parameter int ADDR_WIDTH_LVLS_STATES = 9
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_load,
    input  logic [WIDTH_BIN_ID-1:0]           request_bin_num_i,
    input  logic [WIDTH_LVL-1:0]              base_lvl_i,
    output logic                              apply_load_o,
    output logic                              done_load,
    output logic [NUM_CLAUSES_A_BIN-1:0]      wr_carray_o,
    output logic [WIDTH_CLAUSES-1:0]          clause_o,
    output logic [NUM_VARS_A_BIN-1:0]         wr_var_states_o,
    output logic [WIDTH_VAR_STATES-1:0]       var_state_o,
    output logic [NUM_LVLS_A_BIN-1:0]         wr_lvl_states_o,
    output logic [WIDTH_LVL_STATES-1:0]       lvl_state_o,
    output logic [ADDR_WIDTH_CLAUSES-1:0]     ram_addr_c_o,
    input  logic [WIDTH_CLAUSES-1:0]          ram_data_c_i,
    output logic [ADDR_WIDTH_VARS-1:0]        ram_addr_v_o,
    input  logic [WIDTH_VARS-1:0]             ram_data_v_i,
    output logic [ADDR_WIDTH_VARS_STATES-1:0] ram_addr_v_state_o,
    input  logic [WIDTH_VAR_STATES-1:0]       ram_data_v_state_i,
    output logic [ADDR_WIDTH_LVLS_STATES-1:0] ram_addr_l_state_o,
    input  logic [WIDTH_LVL_STATES-1:0]       ram_data_l_state_i
);

    localparam int NC  = NUM_CLAUSES_A_BIN;
    localparam int NV  = NUM_VARS_A_BIN;
    localparam int NL  = NUM_LVLS_A_BIN;
    localparam int M   = (NC > NV) ? ((NC > NL) ? NC : NL) : ((NV > NL) ? NV : NL);
    localparam int KW  = (M > 1) ? $clog2(M) : 1;
    localparam int CW0 = $clog2(M + 1);
    localparam int CW  = (CW0 > 2) ? CW0 : 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CW-1:0] LAST_LOAD = CW'(M - 1);
    localparam logic [CW-1:0] LAST_WAIT = CW'(3);
    localparam logic [CW-1:0] NC_K      = CW'(NC);
    localparam logic [CW-1:0] NV_K      = CW'(NV);
    localparam logic [CW-1:0] NL_K      = CW'(NL);

    logic [1:0]              state_reg;
    logic [CW-1:0]           cnt_reg;
    logic [WIDTH_BIN_ID-1:0] bin_reg;
    logic [WIDTH_LVL-1:0]    base_reg;

    logic c_act, v_act, l_act;

    // Stage 1: RAM data for slot valid; stage 2/3 only exist for the indirect var path
    logic          c_v1_reg, l_v1_reg, v_v1_reg, v_v2_reg, v_v3_reg;
    logic [KW-1:0] c_slot1_reg, l_slot1_reg, v_slot1_reg, v_slot2_reg, v_slot3_reg;
    logic          v_empty2_reg, v_empty3_reg;

    logic [NC-1:0] c_hot;
    logic [NL-1:0] l_hot;
    logic [NV-1:0] v_hot;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bin_reg   <= '0;
            base_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_load) begin
                        state_reg <= LOAD;
                        cnt_reg   <= '0;
                        bin_reg   <= request_bin_num_i;
                        base_reg  <= base_lvl_i;
                    end
                end
                LOAD: begin
                    if (cnt_reg == LAST_LOAD) begin
                        state_reg <= WAIT;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_reg == LAST_WAIT) begin
                        state_reg <= DONE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign c_act = (state_reg == LOAD) && (cnt_reg < NC_K);
    assign v_act = (state_reg == LOAD) && (cnt_reg < NV_K);
    assign l_act = (state_reg == LOAD) && (cnt_reg < NL_K);

    // Address sums wrap modulo the RAM address width
    assign ram_addr_c_o = c_act ?
        ADDR_WIDTH_CLAUSES'(32'(bin_reg) * 32'(NC) + 32'(cnt_reg)) : '0;
    assign ram_addr_v_o = v_act ?
        ADDR_WIDTH_VARS'(32'(bin_reg) * 32'(NV) + 32'(cnt_reg)) : '0;
    assign ram_addr_l_state_o = l_act ?
        ADDR_WIDTH_LVLS_STATES'(32'(base_reg) + 32'(cnt_reg)) : '0;

    assign apply_load_o = (state_reg != IDLE);
    assign done_load    = (state_reg == DONE);

    generate
        for (genvar gi = 0; gi < NC; gi++) begin : g_c_hot
            assign c_hot[gi] = (c_slot1_reg == KW'(gi));
        end
        for (genvar gi = 0; gi < NL; gi++) begin : g_l_hot
            assign l_hot[gi] = (l_slot1_reg == KW'(gi));
        end
        for (genvar gi = 0; gi < NV; gi++) begin : g_v_hot
            assign v_hot[gi] = (v_slot3_reg == KW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            c_v1_reg           <= 1'b0;
            l_v1_reg           <= 1'b0;
            v_v1_reg           <= 1'b0;
            v_v2_reg           <= 1'b0;
            v_v3_reg           <= 1'b0;
            c_slot1_reg        <= '0;
            l_slot1_reg        <= '0;
            v_slot1_reg        <= '0;
            v_slot2_reg        <= '0;
            v_slot3_reg        <= '0;
            v_empty2_reg       <= 1'b0;
            v_empty3_reg       <= 1'b0;
            wr_carray_o        <= '0;
            clause_o           <= '0;
            wr_lvl_states_o    <= '0;
            lvl_state_o        <= '0;
            wr_var_states_o    <= '0;
            var_state_o        <= '0;
            ram_addr_v_state_o <= '0;
        end else begin
            c_v1_reg    <= c_act;
            l_v1_reg    <= l_act;
            v_v1_reg    <= v_act;
            c_slot1_reg <= KW'(cnt_reg);
            l_slot1_reg <= KW'(cnt_reg);
            v_slot1_reg <= KW'(cnt_reg);

            wr_carray_o     <= c_v1_reg ? c_hot : '0;
            clause_o        <= c_v1_reg ? ram_data_c_i : '0;
            wr_lvl_states_o <= l_v1_reg ? l_hot : '0;
            lvl_state_o     <= l_v1_reg ? ram_data_l_state_i : '0;

            // Var ID becomes the var-state address; ID 0 marks an empty slot
            ram_addr_v_state_o <= v_v1_reg ? ADDR_WIDTH_VARS_STATES'(ram_data_v_i) : '0;
            v_v2_reg     <= v_v1_reg;
            v_slot2_reg  <= v_slot1_reg;
            v_empty2_reg <= (ram_data_v_i == '0);

            v_v3_reg     <= v_v2_reg;
            v_slot3_reg  <= v_slot2_reg;
            v_empty3_reg <= v_empty2_reg;

            wr_var_states_o <= v_v3_reg ? v_hot : '0;
            var_state_o     <= (v_v3_reg && !v_empty3_reg) ? ram_data_v_state_i : '0;
        end
    end

endmodule

// File: tb/tb_load_bin.sv
// Randomized self-checking bench for load_bin: RAM models plus a per-cycle expectation
// model derived from the slot/cycle timing rules.
module tb_load_bin;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_load;
    logic [9:0]  request_bin_num_i;
    logic [15:0] base_lvl_i;
    logic        apply_load_o, done_load;
    logic [7:0]  wr_carray_o, wr_var_states_o, wr_lvl_states_o;
    logic [15:0] clause_o;
    logic [29:0] var_state_o, lvl_state_o;
    logic [8:0]  ram_addr_c_o, ram_addr_v_o, ram_addr_v_state_o, ram_addr_l_state_o;
    logic [15:0] ram_data_c_i;
    logic [11:0] ram_data_v_i;
    logic [29:0] ram_data_v_state_i, ram_data_l_state_i;

    logic [15:0] mem_c  [512];
    logic [11:0] mem_v  [512];
    logic [29:0] mem_vs [512];
    logic [29:0] mem_l  [512];

    int n_checks = 0;
    int n_fail   = 0;
    int cur_bin  = 0;
    int cur_base = 0;

    always #5 clk = ~clk;

    load_bin dut (
        .clk(clk), .rst(rst), .start_load(start_load),
        .request_bin_num_i(request_bin_num_i), .base_lvl_i(base_lvl_i),
        .apply_load_o(apply_load_o), .done_load(done_load),
        .wr_carray_o(wr_carray_o), .clause_o(clause_o),
        .wr_var_states_o(wr_var_states_o), .var_state_o(var_state_o),
        .wr_lvl_states_o(wr_lvl_states_o), .lvl_state_o(lvl_state_o),
        .ram_addr_c_o(ram_addr_c_o), .ram_data_c_i(ram_data_c_i),
        .ram_addr_v_o(ram_addr_v_o), .ram_data_v_i(ram_data_v_i),
        .ram_addr_v_state_o(ram_addr_v_state_o), .ram_data_v_state_i(ram_data_v_state_i),
        .ram_addr_l_state_o(ram_addr_l_state_o), .ram_data_l_state_i(ram_data_l_state_i)
    );

    // Synchronous-read RAMs, one cycle latency
    always @(posedge clk) begin
        ram_data_c_i       <= mem_c[ram_addr_c_o];
        ram_data_v_i       <= mem_v[ram_addr_v_o];
        ram_data_v_state_i <= mem_vs[ram_addr_v_state_o];
        ram_data_l_state_i <= mem_l[ram_addr_l_state_o];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // t = cycle offset from the start_load sampling cycle S
    task automatic check_cycle(input int t);
        int k, j, id;
        logic [63:0] e_ac, e_av, e_al, e_wc, e_c, e_wl, e_l, e_avs, e_wv, e_v;
        k = t - 1;
        e_ac = 0; e_av = 0; e_al = 0; e_wc = 0; e_c = 0;
        e_wl = 0; e_l = 0; e_avs = 0; e_wv = 0; e_v = 0;
        if (k >= 0 && k < 8) begin
            e_ac = 64'((cur_bin * 8 + k) % 512);
            e_av = 64'((cur_bin * 8 + k) % 512);
            e_al = 64'((cur_base + k) % 512);
        end
        j = t - 3;
        if (j >= 0 && j < 8) begin
            e_wc  = 64'(1) << j;
            e_c   = 64'(mem_c[(cur_bin * 8 + j) % 512]);
            e_wl  = 64'(1) << j;
            e_l   = 64'(mem_l[(cur_base + j) % 512]);
            id    = int'(mem_v[(cur_bin * 8 + j) % 512]);
            e_avs = 64'(id % 512);
        end
        j = t - 5;
        if (j >= 0 && j < 8) begin
            id   = int'(mem_v[(cur_bin * 8 + j) % 512]);
            e_wv = 64'(1) << j;
            e_v  = (id == 0) ? 64'(0) : 64'(mem_vs[id % 512]);
        end
        check($sformatf("addr_c t%0d", t), 64'(ram_addr_c_o), e_ac);
        check($sformatf("addr_v t%0d", t), 64'(ram_addr_v_o), e_av);
        check($sformatf("addr_l t%0d", t), 64'(ram_addr_l_state_o), e_al);
        check($sformatf("addr_vs t%0d", t), 64'(ram_addr_v_state_o), e_avs);
        check($sformatf("wr_c t%0d", t), 64'(wr_carray_o), e_wc);
        check($sformatf("clause t%0d", t), 64'(clause_o), e_c);
        check($sformatf("wr_l t%0d", t), 64'(wr_lvl_states_o), e_wl);
        check($sformatf("lvl t%0d", t), 64'(lvl_state_o), e_l);
        check($sformatf("wr_v t%0d", t), 64'(wr_var_states_o), e_wv);
        check($sformatf("var t%0d", t), 64'(var_state_o), e_v);
        check($sformatf("apply t%0d", t), 64'(apply_load_o), 64'(t >= 1 && t <= 13));
        check($sformatf("done t%0d", t), 64'(done_load), 64'(t == 13));
    endtask

    task automatic check_idle(input string tag);
        logic [63:0] all;
        all = {ram_addr_c_o, ram_addr_v_o, ram_addr_l_state_o, ram_addr_v_state_o,
               wr_carray_o, wr_var_states_o, wr_lvl_states_o, apply_load_o, done_load};
        check({tag, " ctl"}, all, 64'(0));
        check({tag, " data"}, 64'(clause_o) | 64'(var_state_o) | 64'(lvl_state_o), 64'(0));
    endtask

    // One load; poke pulses an ignored start at S+4; rst_at>0 resets at S+rst_at
    task automatic run_load(input int bin, input int base, input bit poke, input int rst_at);
        cur_bin  = bin;
        cur_base = base;
        for (int t = 0; t <= 13; t++) begin
            @(posedge clk); #1;
            check_cycle(t);
            start_load = (t == 0) || (poke && t == 4);
            request_bin_num_i = (t == 0) ? 10'(bin) : 10'($urandom);
            base_lvl_i        = (t == 0) ? 16'(base) : 16'($urandom);
            if (rst_at > 0 && t == rst_at) begin
                rst = 1'b1;
                break;
            end
        end
        if (rst_at > 0) begin
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                rst = 1'b0;
                start_load = 1'b0;
                check_idle($sformatf("post_rst c%0d", i));
            end
        end
        $display("load bin=%0d base=%0d poke=%0d rst_at=%0d checks=%0d fails=%0d",
                 bin, base, poke, rst_at, n_checks, n_fail);
    endtask

    task automatic fill_directed(input bit empty_slot);
        int ids[8] = '{5, 9, 2, 7, 11, 4, 3, 8};
        for (int a = 0; a < 512; a++) begin
            mem_c[a]  = 16'(32'h1000 + a);
            mem_v[a]  = 12'(a % 13);
            mem_vs[a] = 30'(a * 3);
            mem_l[a]  = 30'(a + 32'h50);
        end
        for (int k = 0; k < 8; k++) mem_v[24 + k] = 12'(ids[k]);
        if (empty_slot) begin
            mem_v[26] = 12'd0;
            mem_vs[0] = 30'h3FF;
        end
    endtask

    task automatic fill_random();
        for (int a = 0; a < 512; a++) begin
            mem_c[a]  = 16'($urandom);
            mem_v[a]  = ($urandom_range(3) == 0) ? 12'd0 : 12'($urandom);
            mem_vs[a] = 30'($urandom);
            mem_l[a]  = 30'($urandom);
        end
    endtask

    initial begin
        rst = 1'b1;
        start_load = 1'b0;
        request_bin_num_i = '0;
        base_lvl_i = '0;
        fill_directed(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;

        run_load(3, 100, 1'b0, 0);
        fill_directed(1'b1);
        run_load(3, 100, 1'b1, 0);
        run_load(3, 100, 1'b0, 5);
        fill_directed(1'b1);
        run_load(3, 100, 1'b0, 0);
        run_load(1023, 65530, 1'b0, 0);

        for (int n = 0; n < 12; n++) begin
            fill_random();
            run_load(int'($urandom_range(1023)), int'($urandom_range(65535)),
                     1'($urandom), (n == 6) ? int'($urandom_range(1, 12)) : 0);
        end

        @(posedge clk); #1;
        check_idle("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
